// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO input conditioner.
//   GPIO_WIDTH          default number of input lines
//   GPIO_DB_CYCLES      default debounce length in enabled clock edges
//   GPIO_DB_CYCLES_SIM  short debounce length used by simulation benches
//   db_state_e          per-bit debounce state
package gpio_pkg;

  localparam int GPIO_WIDTH         = 8;
  localparam int GPIO_DB_CYCLES     = 16;
  localparam int GPIO_DB_CYCLES_SIM = 4;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: conditions one raw switch line.
//   Two-flop synchroniser (always clocked), then a stability counter that
//   accepts a new level only after it has differed from the current stable
//   level for DB_CYCLES enabled edges. Any reversion drops the candidate.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   en           clock enable for the counter (synchroniser ignores it)
//   raw          asynchronous switch level
//   stable       debounced level
//   pulse        registered one-cycle strobe after stable changes
//   load         combinational: stable updates on the coming edge
//   state_dbg    current FSM state, for debug visibility
module debounce_bit
  import gpio_pkg::*;
#(
  parameter  int DB_CYCLES = GPIO_DB_CYCLES,
  localparam int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      raw,
  output logic      stable,
  output logic      pulse,
  output logic      load,
  output db_state_e state_dbg
);

  logic             sync1, sync2;
  db_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             stable_n;

  // Synchroniser runs every edge so the sampled level stays current even
  // while counting is paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= STABLE;
      cnt    <= '0;
      stable <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      stable <= stable_n;
      pulse  <= load;
    end
  end

  // The entry into PENDING counts as the first stable edge, so the terminal
  // count DB_CYCLES-1 is reached on the DB_CYCLES-th enabled edge.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stable_n = stable;
    load     = 1'b0;
    unique case (state)
      STABLE: begin
        if (sync2 != stable && en) begin
          cnt_n   = CNT_W'(1);
          state_n = PENDING;
        end
      end
      PENDING: begin
        // Reversion is checked regardless of en.
        if (sync2 == stable) begin
          cnt_n   = '0;
          state_n = STABLE;
        end else if (en) begin
          if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            stable_n = sync2;
            cnt_n    = '0;
            load     = 1'b1;
            state_n  = STABLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = STABLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: input-side GPIO conditioner.
//   Each raw line is synchronised and debounced independently; gpio_stable
//   feeds the processor GPIO input, change_pulse strobes for one cycle on
//   every accepted change.
//   Build option GPIO_CHANGE_FLAGS_EN: when defined, sticky per-bit change
//   flags with write-one-to-clear and an OR-reduced irq are implemented.
//   When undefined, flags and irq read 0 and flags_clr is ignored.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   en             debounce counter clock enable
//   gpio_raw       raw switch levels
//   gpio_stable    debounced levels
//   change_pulse   one-cycle change strobes
//   flags          sticky change flags
//   flags_clr      per-bit clear for flags (set wins over clear)
//   irq            OR of flags
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_WIDTH,
  parameter int DB_CYCLES = GPIO_DB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] gpio_raw,
  output logic [WIDTH-1:0] gpio_stable,
  output logic [WIDTH-1:0] change_pulse,
  output logic [WIDTH-1:0] flags,
  input  logic [WIDTH-1:0] flags_clr,
  output logic             irq
);

  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] pending_dbg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    db_state_e st;

    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .raw       (gpio_raw[i]),
      .stable    (gpio_stable[i]),
      .pulse     (change_pulse[i]),
      .load      (load[i]),
      .state_dbg (st)
    );

    assign pending_dbg[i] = (st == PENDING);
  end

`ifdef GPIO_CHANGE_FLAGS_EN
  // Flags are set on the edge that raises change_pulse, hence the use of
  // the pre-register load strobe. Set is applied after clear so it wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~flags_clr) | load;
    end
  end

  assign irq = |flags;

  logic unused_ok;
  assign unused_ok = ^pending_dbg;
`else
  assign flags = '0;
  assign irq   = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{flags_clr, load, pending_dbg};
`endif

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-side GPIO conditioner placed between the board switches and the processor's `GPIO_i` port. It synchronises each raw switch line into the `clk` domain, debounces it with a per-bit stability counter, and presents a clean level plus single-cycle change strobes. An optional latched change-flag/interrupt path lets software poll or acknowledge input events.

## Interface
- `WIDTH`, 8: number of GPIO input lines.
- `DB_CYCLES`, 16: enabled edges for which a new level must be stable before acceptance; legal range 2..65535.
- `CNT_W`, `$clog2(DB_CYCLES)`: counter width; derived, not overridden.

- `clk` in 1: system clock; one clock domain. All logic uses the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: clock enable for the debounce counters.
- `gpio_raw` in WIDTH: raw, asynchronous switch levels.
- `gpio_stable` out WIDTH: debounced level that drives `GPIO_i`.
- `change_pulse` out WIDTH: one-cycle strobe per bit when `gpio_stable` changes.
- `flags` out WIDTH: sticky change flags.
- `flags_clr` in WIDTH: per-bit write-one-to-clear for `flags`.
- `irq` out 1: OR-reduction of `flags`.

## Operation
- **Synchroniser:** two flip-flops per bit, `sync1` then `sync2`, clocked every edge regardless of `en`.
- **Per-bit FSM:**
  - `STABLE` (cnt=0): if `sync2 == gpio_stable[i]`, stay. If they differ and `en`=1, set cnt to 1 and go to `PENDING`.
  - `PENDING`: if `sync2 == gpio_stable[i]`, clear cnt to 0 and return to `STABLE` (glitch rejected, no pulse).
  - `PENDING`, `sync2` still differs, `en`=1:
    - If cnt == DB_CYCLES-1: load `gpio_stable[i] <= sync2`, clear cnt, assert `change_pulse[i]`, return to `STABLE`.
    - Otherwise: increment cnt.
  - `en`=0: cnt and state hold. The mismatch check still runs, so a reversion during `en`=0 still clears cnt.
- **`change_pulse[i]`:** registered. It is high for exactly the one cycle after the edge that updated `gpio_stable[i]`. Rising and falling changes pulse alike.
- **`flags[i]`:** set on the same edge that raises `change_pulse[i]`. Cleared on an edge where `flags_clr[i]`=1. If set and clear happen on the same edge, set wins.
- **`irq`:** combinational OR of `flags`.
- **Counter width:** cnt never exceeds DB_CYCLES-1, so there is no wrap-around.
- **Reset values:** all outputs, synchronisers, counters and states are 0 / `STABLE`. Reset asserted mid-count discards the pending change with no pulse. After reset release, a switch already high reports a rising change after the normal latency.

## Timing
- With `en`=1 continuously: a raw level captured into `sync1` at edge k reaches `sync2` at edge k+1.
- The mismatch is then counted at edges k+2 … k+1+DB_CYCLES.
- `gpio_stable` and `change_pulse` update at edge k+1+DB_CYCLES. `flags` updates on that same edge.
- A raw pulse shorter than DB_CYCLES enabled edges (after synchronisation) never reaches `gpio_stable`.
- With `en` gating, latency is counted in enabled edges, plus the two synchroniser edges.
- Bits are fully independent; simultaneous changes on several bits pulse in the same cycle.

## Configuration
- **`GPIO_CHANGE_FLAGS_EN` defined:** sticky flags, `flags_clr` and `irq` are implemented as above.
- **`GPIO_CHANGE_FLAGS_EN` undefined:**
  - Ports remain present.
  - `flags` and `irq` are tied to 0.
  - `flags_clr` is ignored.
  - No flag registers are synthesised.
  - `gpio_stable` and `change_pulse` are unaffected.

## Structure
- **Shared package `gpio_pkg`:**
  - Default `GPIO_WIDTH` (8) and `GPIO_DB_CYCLES` (16).
  - Per-bit state enum (`STABLE`, `PENDING`).
  - Simulation value `GPIO_DB_CYCLES_SIM` (4).
- **Sub-module `debounce_bit`:** synchroniser, counter, FSM and pulse for one line, instantiated WIDTH times by generate.
- **Top level:** the flag/irq logic and the macro live in the top level only.

## Test plan
- **Clean rising edge:** DB_CYCLES=4, `en`=1, `gpio_raw[0]` 0→1 captured at edge k → `gpio_stable[0]`=1 and `change_pulse[0]`=1 at edge k+5, one cycle only; `flags[0]`=1 and `irq`=1.
- **Glitch rejection:** `gpio_raw[3]` high for 3 edges then low → `gpio_stable`, `change_pulse` and `flags` stay 0x00.
- **Clock enable:** `en` toggles 1,0,1,0… during a change → update occurs after 4 enabled edges (edge k+1+7 with alternating enable starting at 1); no pulse while `en`=0.
- **Flag handshake:** `flags`=0x05, then `flags_clr`=0x04 → `flags`=0x01, `irq`=1. Bit 0 re-changes on the same edge as `flags_clr`=0x01 → `flags[0]` stays 1.
- **Reset mid-operation:** assert `reset` with cnt=2 on bit 7 → all outputs 0 immediately. After release with raw=0x80 → rising change on bit 7 after full latency.
- **Macro off:** rerun scenario 1 without `GPIO_CHANGE_FLAGS_EN` → `gpio_stable` and `change_pulse` identical; `flags`=0 and `irq`=0 throughout.
